// File: rtl/mul_vec_issue_ctrl.sv
// Issue/return controller for the fixed-latency vector Vedic multiplier.
// Tracks in-flight ops and buffers results under credit-based flow control.
module mul_vec_issue_ctrl #(
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [1:0]       req_op,
  input  logic [1:0]       req_prec,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic [1:0]       mul_op,
  output logic [1:0]       mul_prec,
  input  logic [31:0]      mul_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 1) + 1;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } ent_t;

  ent_t             mem_q [FIFO_DEPTH];
  ent_t             mem_d [FIFO_DEPTH];
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] err_q, err_d;
  logic [TAG_W-1:0] tag_q [LATENCY];
  logic [TAG_W-1:0] tag_d [LATENCY];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW:0]      cnt_q, cnt_d;

  logic          accept, issue, push, pop;
  logic [CW-1:0] infl, outst;
  ent_t          head;

  assign head      = mem_q[rptr_q];
  assign rsp_valid = (cnt_q != '0);
  assign rsp_data  = head.data;
  assign rsp_tag   = head.tag;
  assign rsp_err   = head.err;
  assign pop       = rsp_valid & rsp_ready;
  assign push      = vld_q[LATENCY-1];

  // Credits count both in-flight ops and queued results, so a
  // non-stallable multiplier can never overrun the FIFO.
  always_comb begin
    infl = '0;
    for (int i = 0; i < LATENCY; i++) begin
      infl = infl + CW'(vld_q[i]);
    end
    outst     = infl + CW'(cnt_q);
    req_ready = rst & ((outst - CW'(pop)) < CW'(FIFO_DEPTH));
  end

  assign accept   = req_valid & req_ready;
  assign issue    = accept & (req_prec != 2'b11);
  assign mul_a    = issue ? req_a    : '0;
  assign mul_b    = issue ? req_b    : '0;
  assign mul_op   = issue ? req_op   : '0;
  assign mul_prec = issue ? req_prec : '0;

  always_comb begin
    vld_d    = '0;
    err_d    = '0;
    tag_d    = tag_q;
    vld_d[0] = accept;
    err_d[0] = (req_prec == 2'b11);
    tag_d[0] = req_tag;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      err_d[i] = err_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
    cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    if (push) begin
      mem_d[wptr_q].data = err_q[LATENCY-1] ? '0 : mul_res;
      mem_d[wptr_q].tag  = tag_q[LATENCY-1];
      mem_d[wptr_q].err  = err_q[LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      err_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      err_q  <= err_d;
      tag_q  <= tag_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      mem_q  <= mem_d;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && cnt_q == (PW+1)'(FIFO_DEPTH)));
`endif

endmodule

// File: tb/tb_mul_vec_issue_ctrl.sv
// Directed bench for mul_vec_issue_ctrl with a behavioural
// fixed-latency vector multiplier and an in-order scoreboard.
module tb_mul_vec_issue_ctrl;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int TW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [31:0]   req_a, req_b;
  logic [1:0]    req_op, req_prec;
  logic [TW-1:0] req_tag;
  logic [31:0]   mul_a, mul_b, mul_res;
  logic [1:0]    mul_op, mul_prec;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          rsp_err;

  mul_vec_issue_ctrl #(
    .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_prec(req_prec), .req_tag(req_tag),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_op(mul_op), .mul_prec(mul_prec), .mul_res(mul_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_acc = 0;
  int acc_cnt  = 0;
  int stalls   = 0;

  typedef struct {
    logic [31:0]   d;
    logic [TW-1:0] t;
    logic          e;
  } exp_t;

  exp_t sbq[$];
  exp_t cur_exp;

  task automatic check(string tag, logic [71:0] got, logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] vmul(logic [31:0] a, logic [31:0] b,
                                       logic [1:0] op, logic [1:0] prec);
    int w;
    logic [31:0] r;
    logic [63:0] xa, xb, p;
    w = (prec == 2'd0) ? 8 : (prec == 2'd1) ? 16 : 32;
    r = '0;
    for (int l = 0; l < 32 / w; l++) begin
      for (int i = 0; i < 64; i++) begin
        if (i < w) begin
          xa[i] = a[l*w+i];
          xb[i] = b[l*w+i];
        end else begin
          xa[i] = (op == 2'd1 || op == 2'd3) ? a[l*w+w-1] : 1'b0;
          xb[i] = (op == 2'd1) ? b[l*w+w-1] : 1'b0;
        end
      end
      p = xa * xb;
      for (int i = 0; i < w; i++) begin
        r[l*w+i] = (op == 2'd0) ? p[i] : p[w+i];
      end
    end
    return r;
  endfunction

  // Multiplier stand-in; idle/zero inputs yield junk the DUT must ignore.
  logic [31:0] mp [LAT];
  always @(posedge clk) begin
    mp[0] <= (mul_a == '0 && mul_b == '0) ? 32'hBAD0_BAD0
           : vmul(mul_a, mul_b, mul_op, mul_prec);
    for (int i = LAT - 1; i > 0; i--) mp[i] <= mp[i-1];
  end
  assign mul_res = mp[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [67:0] em;
    if (rst) begin
      if (req_valid && req_ready) begin
        em = (req_prec == 2'b11) ? '0
           : {req_a, req_b, req_op, req_prec};
        check("mul_issue", 72'({mul_a, mul_b, mul_op, mul_prec}), 72'(em));
        sbq.push_back(cur_exp);
        acc_cnt++;
        last_acc = cyc;
      end else begin
        check("mul_idle", 72'({mul_a, mul_b, mul_op, mul_prec}), 72'(0));
      end
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          check("rsp_spurious", 72'(rsp_tag), 72'(16));
        end else begin
          check("rsp_data", 72'(rsp_data), 72'(sbq[0].d));
          check("rsp_tag", 72'(rsp_tag), 72'(sbq[0].t));
          check("rsp_err", 72'(rsp_err), 72'(sbq[0].e));
          void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [31:0] a, logic [31:0] b, logic [1:0] op,
                      logic [1:0] prec, logic [TW-1:0] tag,
                      logic [31:0] exp_d);
    int n;
    n = 0;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_prec  = prec;
    req_tag   = tag;
    req_valid = 1'b1;
    cur_exp   = '{exp_d, tag, (prec == 2'b11)};
    @(negedge clk);
    if (!req_ready) stalls++;
    while (!req_ready && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) check("send_timeout", 72'(0), 72'(1));
    sync();
    req_valid = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("drain", 72'(sbq.size()), 72'(0));
    sync();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic [1:0]  op, pr;
    int base, n;

    rst       = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_a     = 32'd7;
    req_b     = 32'd6;
    req_op    = 2'd0;
    req_prec  = 2'd2;
    req_tag   = 4'd1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 72'(req_ready), 72'(0));
    check("rst_rsp_valid", 72'(rsp_valid), 72'(0));
    check("rst_rsp", 72'({rsp_data, rsp_tag, rsp_err}), 72'(0));
    check("rst_mul", 72'({mul_a, mul_b, mul_op, mul_prec}), 72'(0));
    sync();
    req_valid = 1'b0;
    rst       = 1'b1;
    sync();

    // 1: basic MUL and first-response latency
    send(32'd7, 32'd6, 2'd0, 2'd2, 4'd3, 32'd42);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("t1_lat", 72'(cyc - last_acc), 72'(LAT + 1));
    check("t1_data", 72'({rsp_data, rsp_tag, rsp_err}),
          72'({32'd42, 4'd3, 1'b0}));
    drain();

    // 2: signed high half and 8-bit lanes
    send(32'hFFFF_FFFF, 32'h2, 2'd1, 2'd2, 4'd4, 32'hFFFF_FFFF);
    send(32'h0203_0405, 32'h0101_0101, 2'd0, 2'd0, 4'd5, 32'h0203_0405);
    drain();

    // 3: illegal precision between legal neighbours
    send(32'd3, 32'd4, 2'd0, 2'd2, 4'd8, 32'd12);
    send(32'd5, 32'd5, 2'd0, 2'd3, 4'd9, 32'd0);
    send(32'd2, 32'd9, 2'd0, 2'd2, 4'd10, 32'd18);
    drain();

    // 4: backpressure limits outstanding ops to DEPTH
    rsp_ready = 1'b0;
    base = acc_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(32'(i + 1), 32'd3, 2'd0, 2'd2, 4'(i), 32'(3 * (i + 1)));
      end
      begin
        repeat (10) @(negedge clk);
        check("t4_acc", 72'(acc_cnt - base), 72'(DEPTH));
        check("t4_ready", 72'(req_ready), 72'(0));
        check("t4_head", 72'({rsp_valid, rsp_tag}), 72'({1'b1, 4'd0}));
        sync();
        rsp_ready = 1'b1;
      end
    join
    drain();

    // 5: random full-throughput stream
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      a  = $urandom | 32'h1;
      b  = $urandom | 32'h1;
      op = 2'($urandom_range(0, 3));
      pr = 2'($urandom_range(0, 2));
      send(a, b, op, pr, 4'(i), vmul(a, b, op, pr));
    end
    check("t5_stalls", 72'(stalls), 72'(0));
    drain();

    // 6: reset with ops in flight and queued
    rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      send(32'(i), 32'd2, 2'd0, 2'd2, 4'(i), 32'(2 * i));
    sync();
    check("t6_pre_valid", 72'(rsp_valid), 72'(1));
    rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("t6_rsp_valid", 72'(rsp_valid), 72'(0));
    check("t6_req_ready", 72'(req_ready), 72'(0));
    check("t6_rsp", 72'({rsp_data, rsp_tag, rsp_err}), 72'(0));
    sync();
    rst       = 1'b1;
    rsp_ready = 1'b1;
    sync();
    send(32'd9, 32'd9, 2'd0, 2'd2, 4'd6, 32'd81);
    send(32'd100, 32'd3, 2'd0, 2'd2, 4'd7, 32'd300);
    drain();
    repeat (8) @(negedge clk);
    check("t6_no_stale", 72'(rsp_valid), 72'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
